// File: rtl/ctl_round.sv
// Duck Hunt game-round sequencer: launches ducks, tracks ammo, misses and rounds.
// Optional ROUND_SPEEDUP_EN: duck horizontal speed rises with each launched round.
module ctl_round #(
    parameter int AMMO_PER_DUCK = 3,
    parameter int MAX_MISSES    = 3,
    parameter int INTRO_FRAMES  = 60,
    parameter int FALL_FRAMES   = 90,
    parameter int ESCAPE_FRAMES = 60,
    parameter int ROUND_W       = 6,
    parameter int BASE_H_SPD    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_frame,
    input  logic               game_start,
    input  logic               hit,
    input  logic               shot_fired,
    input  logic               duck_offscreen,
    output logic               duck_launch,
    output logic               flight_active,
    output logic               fall_active,
    output logic               escape_active,
    output logic               game_over,
    output logic [1:0]         shots_left,
    output logic [1:0]         misses,
    output logic [ROUND_W-1:0] round_cnt,
    output logic [4:0]         duck_h_spd
);

    // state    | meaning
    // IDLE     | after reset, waiting for game_start
    // INTRO    | pre-launch pause, INTRO_FRAMES frames
    // FLIGHT   | duck in the air, player shooting
    // FALL     | duck hit, falling for FALL_FRAMES frames
    // ESCAPE   | duck got away, ESCAPE_FRAMES frames
    // GAMEOVER | MAX_MISSES reached, frozen until game_start
    typedef enum logic [2:0] {
        S_IDLE, S_INTRO, S_FLIGHT, S_FALL, S_ESCAPE, S_GAMEOVER
    } state_t;

    localparam int MAX_FR_A = (INTRO_FRAMES > FALL_FRAMES) ? INTRO_FRAMES : FALL_FRAMES;
    localparam int MAX_FR   = (MAX_FR_A > ESCAPE_FRAMES) ? MAX_FR_A : ESCAPE_FRAMES;
    localparam int CNT_W    = $clog2(MAX_FR) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [1:0]         shots_q, shots_d;
    logic [1:0]         misses_q, misses_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               launch_q, launch_d;
    logic               flight_q, fall_q, escape_q, over_q;

    logic intro_done, fall_done, escape_done;

    assign intro_done  = new_frame && (frame_cnt_q == CNT_W'(INTRO_FRAMES - 1));
    assign fall_done   = new_frame && (frame_cnt_q == CNT_W'(FALL_FRAMES - 1));
    assign escape_done = new_frame && (frame_cnt_q == CNT_W'(ESCAPE_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (game_start) begin
            state_d = S_INTRO;
        end else begin
            case (state_q)
                S_INTRO:  if (intro_done) state_d = S_FLIGHT;
                S_FLIGHT: begin
                    if (hit)                                 state_d = S_FALL;
                    else if (duck_offscreen)                 state_d = S_ESCAPE;
                    else if (shot_fired && shots_q == 2'd1)  state_d = S_ESCAPE;
                end
                S_FALL:   if (fall_done) state_d = S_INTRO;
                S_ESCAPE: if (escape_done)
                    state_d = (misses_q == 2'(MAX_MISSES)) ? S_GAMEOVER : S_INTRO;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        shots_d     = shots_q;
        misses_d    = misses_q;
        round_d     = round_q;
        launch_d    = 1'b0;
        if (game_start) begin
            frame_cnt_d = '0;
            shots_d     = '0;
            misses_d    = '0;
            round_d     = '0;
        end else begin
            if (state_d != state_q)
                frame_cnt_d = '0;
            else if (new_frame && (state_q == S_INTRO || state_q == S_FALL || state_q == S_ESCAPE))
                frame_cnt_d = frame_cnt_q + 1'b1;

            if (state_q == S_INTRO && state_d == S_FLIGHT) begin
                launch_d = 1'b1;
                shots_d  = 2'(AMMO_PER_DUCK);
                round_d  = (round_q == '1) ? round_q : round_q + 1'b1;
            end

            // an offscreen duck without a hit swallows the shot
            if (state_q == S_FLIGHT && shot_fired && (hit || !duck_offscreen) && shots_q != 2'd0)
                shots_d = shots_q - 2'd1;

            if (state_d == S_ESCAPE && state_q != S_ESCAPE && misses_q != 2'(MAX_MISSES))
                misses_d = misses_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q <= '0;
            shots_q     <= '0;
            misses_q    <= '0;
            round_q     <= '0;
            launch_q    <= 1'b0;
            flight_q    <= 1'b0;
            fall_q      <= 1'b0;
            escape_q    <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            shots_q     <= shots_d;
            misses_q    <= misses_d;
            round_q     <= round_d;
            launch_q    <= launch_d;
            flight_q    <= (state_d == S_FLIGHT);
            fall_q      <= (state_d == S_FALL);
            escape_q    <= (state_d == S_ESCAPE);
            over_q      <= (state_d == S_GAMEOVER);
        end
    end

`ifdef ROUND_SPEEDUP_EN
    logic [ROUND_W+3:0] rnd_m1_w;
    logic [3:0]         spd_add;
    logic [5:0]         spd_sum;
    logic [4:0]         spd_q;

    always_comb begin
        rnd_m1_w = {4'b0, round_d} - 1'b1;
        spd_add  = (rnd_m1_w > (ROUND_W+4)'(15)) ? 4'd15 : rnd_m1_w[3:0];
        spd_sum  = 6'(BASE_H_SPD) + {2'b0, spd_add};
    end

    always_ff @(posedge clk) begin
        if (!rst || game_start) spd_q <= 5'(BASE_H_SPD);
        else if (launch_d)      spd_q <= (spd_sum > 6'd31) ? 5'd31 : spd_sum[4:0];
    end

    assign duck_h_spd = spd_q;
`else
    assign duck_h_spd = 5'(BASE_H_SPD);
`endif

    assign duck_launch   = launch_q;
    assign flight_active = flight_q;
    assign fall_active   = fall_q;
    assign escape_active = escape_q;
    assign game_over     = over_q;
    assign shots_left    = shots_q;
    assign misses        = misses_q;
    assign round_cnt     = round_q;

endmodule

// File: tb/tb_ctl_round.sv
// Directed self-checking bench for ctl_round with default parameters.
module tb_ctl_round;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       new_frame = 1'b0, game_start = 1'b0, hit = 1'b0;
    logic       shot_fired = 1'b0, duck_offscreen = 1'b0;
    logic       duck_launch, flight_active, fall_active, escape_active, game_over;
    logic [1:0] shots_left, misses;
    logic [5:0] round_cnt;
    logic [4:0] duck_h_spd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ctl_round dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .game_start(game_start),
        .hit(hit), .shot_fired(shot_fired), .duck_offscreen(duck_offscreen),
        .duck_launch(duck_launch), .flight_active(flight_active),
        .fall_active(fall_active), .escape_active(escape_active),
        .game_over(game_over), .shots_left(shots_left), .misses(misses),
        .round_cnt(round_cnt), .duck_h_spd(duck_h_spd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Gives n new_frame pulses separated by idle cycles, counting launch pulses.
    task automatic frames(input int n, output int launches);
        launches = 0;
        for (int i = 0; i < n; i++) begin
            new_frame = 1'b1;
            step();
            new_frame = 1'b0;
            if (duck_launch) launches++;
            step();
            if (duck_launch) launches++;
        end
    endtask

    task automatic start_game();
        game_start = 1'b1;
        step();
        game_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_cmp++; if ({duck_launch, flight_active, fall_active, escape_active, game_over} !== 5'b0) begin n_bad++; $display("FAIL reset_levels: got %b want 00000", {duck_launch, flight_active, fall_active, escape_active, game_over}); end
        n_cmp++; if ({shots_left, misses, round_cnt} !== 10'd0) begin n_bad++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", shots_left, misses, round_cnt); end
        n_cmp++; if (duck_h_spd !== 5'd10) begin n_bad++; $display("FAIL reset_spd: got %0d want 10", duck_h_spd); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_start();
        int l;
        start_game();
        frames(59, l);
        n_cmp++; if (l !== 0 || flight_active !== 1'b0) begin n_bad++; $display("FAIL intro_59: got launches %0d flight %b want 0 0", l, flight_active); end
        frames(1, l);
        n_cmp++; if (l !== 1) begin n_bad++; $display("FAIL launch_once: got %0d want 1", l); end
        n_cmp++; if (shots_left !== 2'd3 || round_cnt !== 6'd1 || flight_active !== 1'b1) begin n_bad++; $display("FAIL launch_state: got shots %0d round %0d flight %b want 3 1 1", shots_left, round_cnt, flight_active); end
        n_cmp++; if (duck_h_spd !== 5'd10) begin n_bad++; $display("FAIL launch1_spd: got %0d want 10", duck_h_spd); end
    endtask

    task automatic test_hit();
        int l;
        shot_fired = 1'b1; hit = 1'b1;
        step();
        shot_fired = 1'b0; hit = 1'b0;
        n_cmp++; if (shots_left !== 2'd2 || fall_active !== 1'b1 || flight_active !== 1'b0) begin n_bad++; $display("FAIL hit_shot: got shots %0d fall %b flight %b want 2 1 0", shots_left, fall_active, flight_active); end
        frames(89, l);
        n_cmp++; if (fall_active !== 1'b1) begin n_bad++; $display("FAIL fall_89: got fall %b want 1", fall_active); end
        frames(1, l);
        n_cmp++; if (fall_active !== 1'b0 || misses !== 2'd0) begin n_bad++; $display("FAIL fall_exit: got fall %b misses %0d want 0 0", fall_active, misses); end
        frames(60, l);
        n_cmp++; if (l !== 1 || round_cnt !== 6'd2 || shots_left !== 2'd3) begin n_bad++; $display("FAIL second_launch: got launches %0d round %0d shots %0d want 1 2 3", l, round_cnt, shots_left); end
    endtask

    task automatic test_ammo();
        int l;
        logic [1:0] exp_shots [3] = '{2'd2, 2'd1, 2'd0};
        for (int i = 0; i < 3; i++) begin
            shot_fired = 1'b1;
            step();
            shot_fired = 1'b0;
            step();
            n_cmp++; if (shots_left !== exp_shots[i]) begin n_bad++; $display("FAIL ammo_shot%0d: got %0d want %0d", i, shots_left, exp_shots[i]); end
        end
        n_cmp++; if (escape_active !== 1'b1 || misses !== 2'd1 || flight_active !== 1'b0) begin n_bad++; $display("FAIL ammo_escape: got esc %b misses %0d flight %b want 1 1 0", escape_active, misses, flight_active); end
        frames(60, l);
        n_cmp++; if (escape_active !== 1'b0 || game_over !== 1'b0 || misses !== 2'd1) begin n_bad++; $display("FAIL escape_exit: got esc %b over %b misses %0d want 0 0 1", escape_active, game_over, misses); end
    endtask

    task automatic test_game_over();
        int l;
        start_game();
        n_cmp++; if (misses !== 2'd0 || round_cnt !== 6'd0 || shots_left !== 2'd0) begin n_bad++; $display("FAIL restart_clear: got %0d/%0d/%0d want 0/0/0", misses, round_cnt, shots_left); end
        for (int k = 1; k <= 3; k++) begin
            frames(60, l);
            duck_offscreen = 1'b1;
            step();
            duck_offscreen = 1'b0;
            n_cmp++; if (escape_active !== 1'b1 || misses !== 2'(k)) begin n_bad++; $display("FAIL offscreen%0d: got esc %b misses %0d want 1 %0d", k, escape_active, misses, k); end
            frames(60, l);
        end
        n_cmp++; if (game_over !== 1'b1 || misses !== 2'd3 || round_cnt !== 6'd3) begin n_bad++; $display("FAIL game_over: got over %b misses %0d round %0d want 1 3 3", game_over, misses, round_cnt); end
        shot_fired = 1'b1; hit = 1'b1;
        step();
        shot_fired = 1'b0; hit = 1'b0;
        frames(70, l);
        n_cmp++; if (game_over !== 1'b1 || shots_left !== 2'd3 || misses !== 2'd3 || round_cnt !== 6'd3 || l !== 0) begin n_bad++; $display("FAIL over_frozen: got over %b shots %0d misses %0d round %0d launches %0d want 1 3 3 3 0", game_over, shots_left, misses, round_cnt, l); end
        start_game();
        n_cmp++; if (game_over !== 1'b0 || misses !== 2'd0 || round_cnt !== 6'd0) begin n_bad++; $display("FAIL over_restart: got over %b misses %0d round %0d want 0 0 0", game_over, misses, round_cnt); end
    endtask

    task automatic test_simultaneous();
        int l;
        // start already issued; a start coinciding with a frame must not count it
        frames(30, l);
        game_start = 1'b1; new_frame = 1'b1;
        step();
        game_start = 1'b0; new_frame = 1'b0;
        frames(59, l);
        n_cmp++; if (l !== 0) begin n_bad++; $display("FAIL start_frame_uncounted: got launches %0d want 0", l); end
        frames(1, l);
        n_cmp++; if (l !== 1 || round_cnt !== 6'd1) begin n_bad++; $display("FAIL start_frame_launch: got launches %0d round %0d want 1 1", l, round_cnt); end
        hit = 1'b1; duck_offscreen = 1'b1;
        step();
        hit = 1'b0; duck_offscreen = 1'b0;
        n_cmp++; if (fall_active !== 1'b1 || escape_active !== 1'b0 || misses !== 2'd0 || shots_left !== 2'd3) begin n_bad++; $display("FAIL hit_and_offscreen: got fall %b esc %b misses %0d shots %0d want 1 0 0 3", fall_active, escape_active, misses, shots_left); end
        frames(150, l);
        n_cmp++; if (flight_active !== 1'b1 || round_cnt !== 6'd2) begin n_bad++; $display("FAIL relaunch: got flight %b round %0d want 1 2", flight_active, round_cnt); end
        rst = 1'b0;
        step();
        n_cmp++; if ({duck_launch, flight_active, fall_active, escape_active, game_over, shots_left, misses, round_cnt} !== 15'd0 || duck_h_spd !== 5'd10) begin n_bad++; $display("FAIL mid_reset: got flight %b shots %0d round %0d spd %0d want 0 0 0 10", flight_active, shots_left, round_cnt, duck_h_spd); end
        rst = 1'b1;
        frames(70, l);
        n_cmp++; if (l !== 0 || flight_active !== 1'b0) begin n_bad++; $display("FAIL idle_holds: got launches %0d flight %b want 0 0", l, flight_active); end
    endtask

    task automatic test_speed();
        int l;
        logic [4:0] exp_spd;
        start_game();
        for (int k = 1; k <= 18; k++) begin
            frames(60, l);
`ifdef ROUND_SPEEDUP_EN
            exp_spd = (k <= 16) ? 5'(9 + k) : 5'd25;
`else
            exp_spd = 5'd10;
`endif
            if (k == 1 || k == 2 || k == 3 || k == 16 || k == 18) begin
                n_cmp++; if (duck_h_spd !== exp_spd) begin n_bad++; $display("FAIL speed_launch%0d: got %0d want %0d", k, duck_h_spd, exp_spd); end
            end
            hit = 1'b1;
            step();
            hit = 1'b0;
            n_cmp++; if (duck_h_spd !== exp_spd) begin n_bad++; $display("FAIL speed_hold%0d: got %0d want %0d", k, duck_h_spd, exp_spd); end
            frames(90, l);
        end
        start_game();
        n_cmp++; if (duck_h_spd !== 5'd10) begin n_bad++; $display("FAIL speed_restart: got %0d want 10", duck_h_spd); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_ammo();
        test_game_over();
        test_simultaneous();
        test_speed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
